// File: rtl/tour_pkg.sv
// Shared definitions for the knight's-tour solver: move offsets, scheduler
// states and the board-bounds helper.
package tour_pkg;

    localparam logic signed [2:0] KNIGHT_DX [0:7] =
        '{3'sd1, 3'sd2, 3'sd2, 3'sd1, -3'sd1, -3'sd2, -3'sd2, -3'sd1};
    localparam logic signed [2:0] KNIGHT_DY [0:7] =
        '{3'sd2, 3'sd1, -3'sd1, -3'sd2, -3'sd2, -3'sd1, 3'sd1, 3'sd2};

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WAIT,
        RESULT
    } sched_state_t;

    function automatic logic on_board(input logic signed [7:0] x,
                                      input logic signed [7:0] y,
                                      input logic signed [7:0] dim);
        return (x >= 8'sd0) && (x < dim) && (y >= 8'sd0) && (y < dim);
    endfunction

endpackage

// File: rtl/knight_move_sched.sv
// Knight move-candidate scheduler: scans offsets from start_idx, skipping
// off-board targets and reading the visited bit for on-board ones.
module knight_move_sched
    import tour_pkg::*;
#(
    parameter int BOARD_DIM = 5,
    parameter int COORD_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] cur_x,
    input  logic [COORD_W-1:0] cur_y,
    input  logic [3:0]         start_idx,
    output logic               brd_rd_en,
    output logic [COORD_W-1:0] brd_rd_x,
    output logic [COORD_W-1:0] brd_rd_y,
    input  logic               brd_visited,
    output logic               busy,
    output logic               found,
    output logic               no_move,
    output logic [2:0]         move_idx,
    output logic [COORD_W-1:0] nxt_x,
    output logic [COORD_W-1:0] nxt_y
);

    localparam int TW = COORD_W + 2;
    localparam logic [COORD_W:0]  DIM_C = (COORD_W + 1)'(BOARD_DIM);
    localparam logic signed [7:0] DIM_8 = 8'(BOARD_DIM);

    sched_state_t state, state_n;

    logic [COORD_W-1:0]   cx, cy;
    logic [3:0]           idx;
    logic                 hit;
    logic signed [2:0]    dx, dy;
    logic signed [TW-1:0] tx, ty;
    logic                 tgt_ok;

    // Square outside the board has no legal targets, even if the offset lands on it.
    always_comb begin
        dx     = KNIGHT_DX[idx[2:0]];
        dy     = KNIGHT_DY[idx[2:0]];
        tx     = {2'b00, cx} + {{(TW-3){dx[2]}}, dx};
        ty     = {2'b00, cy} + {{(TW-3){dy[2]}}, dy};
        tgt_ok = ({1'b0, cx} < DIM_C) && ({1'b0, cy} < DIM_C)
                 && on_board(8'(tx), 8'(ty), DIM_8);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        busy      = (state != IDLE);
        found     = 1'b0;
        no_move   = 1'b0;
        brd_rd_en = 1'b0;
        brd_rd_x  = '0;
        brd_rd_y  = '0;
        case (state)
            IDLE: begin
                if (start) state_n = CHECK;
            end
            CHECK: begin
                if (idx[3]) begin
                    state_n = RESULT;
                end else if (tgt_ok) begin
                    brd_rd_en = 1'b1;
                    brd_rd_x  = tx[COORD_W-1:0];
                    brd_rd_y  = ty[COORD_W-1:0];
                    state_n   = WAIT;
                end
            end
            WAIT: begin
                state_n = brd_visited ? CHECK : RESULT;
            end
            RESULT: begin
                found   = hit;
                no_move = !hit;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // idx stays parked at 8 once exhausted; out-of-range start_idx is clamped to 8.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx       <= '0;
            cy       <= '0;
            idx      <= '0;
            hit      <= 1'b0;
            move_idx <= '0;
            nxt_x    <= '0;
            nxt_y    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cx       <= cur_x;
                        cy       <= cur_y;
                        idx      <= start_idx[3] ? 4'd8 : start_idx;
                        hit      <= 1'b0;
                        move_idx <= '0;
                        nxt_x    <= '0;
                        nxt_y    <= '0;
                    end
                end
                CHECK: begin
                    if (!idx[3] && !tgt_ok) idx <= idx + 4'd1;
                end
                WAIT: begin
                    if (brd_visited) begin
                        idx <= idx + 4'd1;
                    end else begin
                        hit      <= 1'b1;
                        move_idx <= idx[2:0];
                        nxt_x    <= tx[COORD_W-1:0];
                        nxt_y    <= ty[COORD_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_knight_move_sched.sv
// Scoreboard bench for knight_move_sched: requests push expected results,
// a monitor pops and compares on every found/no_move pulse.
module tb_knight_move_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] cur_x = '0, cur_y = '0;
    logic [3:0] start_idx = '0;
    logic       brd_rd_en;
    logic [2:0] brd_rd_x, brd_rd_y;
    logic       brd_visited = 1'b0;
    logic       busy, found, no_move;
    logic [2:0] move_idx, nxt_x, nxt_y;

    knight_move_sched #(.BOARD_DIM(5), .COORD_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .cur_x(cur_x), .cur_y(cur_y),
        .start_idx(start_idx), .brd_rd_en(brd_rd_en), .brd_rd_x(brd_rd_x),
        .brd_rd_y(brd_rd_y), .brd_visited(brd_visited), .busy(busy),
        .found(found), .no_move(no_move), .move_idx(move_idx),
        .nxt_x(nxt_x), .nxt_y(nxt_y)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit fnd;
        int midx, nx, ny, lat, nreads, fx, fy;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0, fails = 0;
    int   cyc = 0, start_cyc = 0;
    int   nreads = 0, first_x = 0, first_y = 0;
    bit   board[0:7][0:7];

    always @(posedge clk) cyc <= cyc + 1;

    // Board memory model; drives noise when no read was issued.
    always @(posedge clk)
        brd_visited <= brd_rd_en ? board[brd_rd_x][brd_rd_y] : 1'($urandom);

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && brd_rd_en) begin
            if (nreads == 0) begin
                first_x = brd_rd_x;
                first_y = brd_rd_y;
            end
            nreads++;
        end
        if (!rst && (found || no_move)) begin
            chk("found_xor_no_move", int'(found & no_move), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("found", int'(found), int'(e.fnd));
                chk("latency", cyc - start_cyc, e.lat);
                chk("reads", nreads, e.nreads);
                if (e.nreads > 0) begin
                    chk("first_rd_x", first_x, e.fx);
                    chk("first_rd_y", first_y, e.fy);
                end
                if (e.fnd) begin
                    chk("move_idx", int'(move_idx), e.midx);
                    chk("nxt_x", int'(nxt_x), e.nx);
                    chk("nxt_y", int'(nxt_y), e.ny);
                end
            end
        end
    end

    task automatic clear_board();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                board[i][j] = 1'b0;
    endtask

    task automatic issue(input int x, input int y, input int si);
        @(negedge clk);
        cur_x     = 3'(x);
        cur_y     = 3'(y);
        start_idx = 4'(si);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_cyc = cyc - 1;
        nreads    = 0;
    endtask

    task automatic push(input bit f, input int mi, input int nx, input int ny,
                        input int lat, input int nr, input int fx, input int fy);
        exp_t e;
        e = '{fnd: f, midx: mi, nx: nx, ny: ny, lat: lat, nreads: nr, fx: fx, fy: fy};
        exp_q.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            chk("result_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic req(input int x, input int y, input int si, input bit f,
                       input int mi, input int nx, input int ny, input int lat,
                       input int nr, input int fx, input int fy);
        push(f, mi, nx, ny, lat, nr, fx, fy);
        issue(x, y, si);
        wait_done();
    endtask

    initial begin
        clear_board();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_found", int'(found), 0);
        chk("rst_no_move", int'(no_move), 0);
        chk("rst_rd_en", int'(brd_rd_en), 0);
        chk("rst_move", int'({move_idx, nxt_x, nxt_y}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        req(0, 0, 0, 1, 0, 1, 2, 3, 1, 1, 2);
        board[1][2] = 1'b1;
        req(0, 0, 0, 1, 1, 2, 1, 5, 2, 1, 2);
        clear_board();
        req(0, 0, 2, 0, 0, 0, 0, 8, 0, 0, 0);
        req(2, 2, 8, 0, 0, 0, 0, 2, 0, 0, 0);
        req(4, 4, 8, 0, 0, 0, 0, 2, 0, 0, 0);
        board[3][4] = 1'b1; board[4][3] = 1'b1; board[4][1] = 1'b1; board[3][0] = 1'b1;
        board[1][0] = 1'b1; board[0][1] = 1'b1; board[0][3] = 1'b1; board[1][4] = 1'b1;
        req(2, 2, 0, 0, 0, 0, 0, 18, 8, 3, 4);
        board[0][1] = 1'b0; board[0][3] = 1'b0; board[1][4] = 1'b0;
        req(2, 2, 3, 1, 5, 0, 1, 7, 3, 3, 0);
        clear_board();
        req(7, 7, 0, 0, 0, 0, 0, 10, 0, 0, 0);
        req(4, 4, 7, 0, 0, 0, 0, 3, 0, 0, 0);
        req(4, 4, 4, 1, 4, 3, 2, 3, 1, 3, 2);

        // Second start mid-scan must be dropped.
        push(0, 0, 0, 0, 8, 0, 0, 0);
        issue(0, 0, 2);
        @(negedge clk);
        chk("busy_mid_scan", int'(busy), 1);
        @(negedge clk);
        cur_x = 3'd2; cur_y = 3'd2; start_idx = 4'd0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        repeat (4) @(negedge clk);
        chk("busy_after_drop", int'(busy), 0);

        // Start presented during the RESULT cycle must be dropped.
        push(0, 0, 0, 0, 2, 0, 0, 0);
        issue(2, 2, 8);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        @(negedge clk);
        chk("busy_after_result_start", int'(busy), 0);

        // Reset while waiting on the board read.
        clear_board();
        issue(0, 0, 0);
        @(posedge clk);
        #2;
        chk("in_wait_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("rst_wait_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        chk("rst_wait_found", int'(found), 0);
        chk("rst_wait_no_move", int'(no_move), 0);
        chk("rst_wait_busy_edge", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("idle_after_rst", int'(busy), 0);

        // Normal operation resumes after the mid-scan reset.
        req(0, 0, 0, 1, 0, 1, 2, 3, 1, 1, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
